// File: rtl/mips_dmem_pkg.sv
// Shared constants and types for the MIPS data-memory responder:
// MMIO register offsets, error-status bit positions and the address-decode result.
package mips_dmem_pkg;

  localparam logic [5:0] OFF_CYCLE_LO   = 6'h00;
  localparam logic [5:0] OFF_CYCLE_HI   = 6'h04;
  localparam logic [5:0] OFF_SCRATCH    = 6'h08;
  localparam logic [5:0] OFF_ERR_STATUS = 6'h0C;
  localparam logic [5:0] OFF_ERR_ADDR   = 6'h10;

  localparam int ERR_MISALIGNED = 0;
  localparam int ERR_UNMAPPED   = 1;
  localparam int ERR_CONFLICT   = 2;
  localparam int ERR_WIDTH      = 3;

  typedef enum logic [1:0] {
    DEC_RAM,
    DEC_MMIO,
    DEC_MISALIGNED,
    DEC_UNMAPPED
  } decode_e;

endpackage

// File: rtl/mips_dmem_mmio_regs.sv
// MMIO register bank: free-running 64-bit cycle counter with HI snapshot,
// scratch register and sticky error status/address with registered error flag.
module mips_dmem_mmio_regs
  import mips_dmem_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [5:0]           regOffset,
  input  logic                 regRead,
  input  logic                 regWrite,
  input  logic [31:0]          writeData,
  input  logic [ERR_WIDTH-1:0] errSet,
  input  logic [31:0]          errAddr,
  output logic [31:0]          regData,
  output logic                 errFlag
);

  logic [63:0]          cycleCountReg;
  logic [31:0]          cycleHiReg;
  logic [31:0]          scratchReg;
  logic [31:0]          errAddrReg;
  logic [ERR_WIDTH-1:0] errStatusReg;
  logic [ERR_WIDTH-1:0] errStatusNext;
  logic [ERR_WIDTH-1:0] errClear;
  logic                 errReg;

  // A new error set on the same edge as a W1C clear of that bit survives.
  always_comb begin
    errClear = '0;
    if (regWrite && regOffset == OFF_ERR_STATUS) errClear = writeData[ERR_WIDTH-1:0];
    errStatusNext = (errStatusReg & ~errClear) | errSet;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycleCountReg <= '0;
      cycleHiReg    <= '0;
      scratchReg    <= '0;
      errAddrReg    <= '0;
      errStatusReg  <= '0;
      errReg        <= 1'b0;
    end else begin
      cycleCountReg <= cycleCountReg + 64'd1;
      if (regRead && regOffset == OFF_CYCLE_LO) cycleHiReg <= cycleCountReg[63:32];
      if (regWrite && regOffset == OFF_SCRATCH) scratchReg <= writeData;
      // Only the first error after an all-clear status records its address.
      if (errStatusReg == '0 && errSet != '0) errAddrReg <= errAddr;
      errStatusReg <= errStatusNext;
      errReg       <= |errStatusReg;
    end
  end

  always_comb begin
    regData = '0;
    case (regOffset)
      OFF_CYCLE_LO:   regData = cycleCountReg[31:0];
      OFF_CYCLE_HI:   regData = cycleHiReg;
      OFF_SCRATCH:    regData = scratchReg;
      OFF_ERR_STATUS: regData = {{(32-ERR_WIDTH){1'b0}}, errStatusReg};
      OFF_ERR_ADDR:   regData = errAddrReg;
      default:        regData = '0;
    endcase
  end

  assign errFlag = errReg;

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-port responder for the 5-stage core: address decoder, zero-latency word RAM,
// read-data mux and the MMIO register bank.
module mips_dmem_responder
  import mips_dmem_pkg::*;
#(
  parameter int          DEPTH         = 1024,
  parameter logic [31:0] MMIO_BASE     = 32'hFFFF_0000,
  parameter logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF
)
(
  input  logic        clock__i,
  input  logic        reset__i,
  input  logic [31:0] memAddr__i,
  input  logic [31:0] memDataWrite__i,
  input  logic        memRead__i,
  input  logic        memWrite__i,
  output logic [31:0] memDataRead__o,
  output logic        err__o
);

  localparam int ADDR_W = $clog2(DEPTH);

  decode_e              decode;
  logic [ADDR_W-1:0]    ramIndex;
  logic [31:0]          ram [DEPTH];
  logic [31:0]          mmioData;
  logic [ERR_WIDTH-1:0] errSet;
  logic                 accessActive;
  logic                 cleanRead;

  assign ramIndex     = memAddr__i[ADDR_W+1:2];
  assign accessActive = memRead__i | memWrite__i;
  assign cleanRead    = memRead__i & ~memWrite__i;

  // Misalignment is checked first so it masks the unmapped classification.
  always_comb begin
    if (memAddr__i[1:0] != 2'b00)                 decode = DEC_MISALIGNED;
    else if (memAddr__i[31:ADDR_W+2] == '0)       decode = DEC_RAM;
    else if (memAddr__i[31:6] == MMIO_BASE[31:6]) decode = DEC_MMIO;
    else                                          decode = DEC_UNMAPPED;
  end

  always_comb begin
    errSet = '0;
    errSet[ERR_MISALIGNED] = accessActive && decode == DEC_MISALIGNED;
    errSet[ERR_UNMAPPED]   = accessActive && decode == DEC_UNMAPPED;
    errSet[ERR_CONFLICT]   = memRead__i & memWrite__i;
  end

  // Combinational read so the core's MEM/WB register can capture data in the same cycle.
  always_ff @(posedge clock__i) begin
    if (memWrite__i && decode == DEC_RAM) ram[ramIndex] <= memDataWrite__i;
  end

  mips_dmem_mmio_regs uMmioRegs (
    .clock     (clock__i),
    .reset     (reset__i),
    .regOffset (memAddr__i[5:0]),
    .regRead   (cleanRead && decode == DEC_MMIO),
    .regWrite  (memWrite__i && decode == DEC_MMIO),
    .writeData (memDataWrite__i),
    .errSet    (errSet),
    .errAddr   (memAddr__i),
    .regData   (mmioData),
    .errFlag   (err__o)
  );

  always_comb begin
    memDataRead__o = '0;
    if (!reset__i && cleanRead) begin
      case (decode)
        DEC_RAM:  memDataRead__o = ram[ramIndex];
        DEC_MMIO: memDataRead__o = mmioData;
        default:  memDataRead__o = UNMAPPED_DATA;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed testbench for mips_dmem_responder: RAM, MMIO registers, error tracking,
// read/write conflicts and asynchronous reset; expected values are hand-computed.
module tb_mips_dmem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic        rd    = 1'b0;
  logic        wr    = 1'b0;
  logic [31:0] rdata;
  logic        err;

  int          errors = 0;
  int          checks = 0;
  longint unsigned modelCount = 0;

  localparam logic [31:0] R_LO   = 32'hFFFF_0000;
  localparam logic [31:0] R_HI   = 32'hFFFF_0004;
  localparam logic [31:0] R_SCR  = 32'hFFFF_0008;
  localparam logic [31:0] R_STAT = 32'hFFFF_000C;
  localparam logic [31:0] R_EADR = 32'hFFFF_0010;

  always #5 clock = ~clock;

  mips_dmem_responder dut (
    .clock__i        (clock),
    .reset__i        (reset),
    .memAddr__i      (addr),
    .memDataWrite__i (wdata),
    .memRead__i      (rd),
    .memWrite__i     (wr),
    .memDataRead__o  (rdata),
    .err__o          (err)
  );

  task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, observed, expected);
    end else begin
      $display("ok   %s: %h", tag, observed);
    end
  endtask

  // One bus cycle: drive after the falling edge, leave 1 time unit before sampling.
  task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w);
    @(negedge clock);
    modelCount++;
    addr = a; wdata = d; rd = r; wr = w;
    #1;
  endtask

  task automatic idle();
    cycle(32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  logic [31:0] loSnap;

  initial begin
    // Reset: outputs gated even with an unmapped read pending
    cycle(32'h0000_1000, 32'h0, 1'b1, 1'b0);
    checkValue("reset_rdata", rdata, 32'h0);
    idle();
    checkValue("reset_err", err, 1'b0);
    @(negedge clock);
    reset = 1'b0; modelCount = 0;

    // Counter after 100 cycles, HI snapshot, reset values
    repeat (99) idle();
    cycle(R_LO, 32'h0, 1'b1, 1'b0);
    checkValue("cycle_lo_100", rdata, modelCount[31:0]);
    cycle(R_HI, 32'h0, 1'b1, 1'b0);
    checkValue("cycle_hi_0", rdata, 32'h0);
    cycle(R_SCR, 32'h0, 1'b1, 1'b0);
    checkValue("scratch_reset", rdata, 32'h0);
    cycle(R_STAT, 32'h0, 1'b1, 1'b0);
    checkValue("status_reset", rdata, 32'h0);
    cycle(R_EADR, 32'h0, 1'b1, 1'b0);
    checkValue("erraddr_reset", rdata, 32'h0);

    // RAM write then read
    cycle(32'h0000_0010, 32'h1234_5678, 1'b0, 1'b1);
    cycle(32'h0000_0010, 32'h0, 1'b1, 1'b0);
    checkValue("ram_rd_10", rdata, 32'h1234_5678);
    cycle(32'h0000_0010, 32'h0, 1'b0, 1'b0);
    checkValue("no_strobe_rdata", rdata, 32'h0);
    checkValue("ram_err_low", err, 1'b0);

    // Unmapped read, then misaligned read
    cycle(32'h0000_1000, 32'h0, 1'b1, 1'b0);
    checkValue("unmapped_rdata", rdata, 32'hDEAD_BEEF);
    cycle(R_STAT, 32'h0, 1'b1, 1'b0);
    checkValue("status_unmapped", rdata, 32'h2);
    checkValue("err_lags_status", err, 1'b0);
    cycle(R_EADR, 32'h0, 1'b1, 1'b0);
    checkValue("erraddr_1000", rdata, 32'h0000_1000);
    checkValue("err_set", err, 1'b1);
    cycle(32'h0000_0003, 32'h0, 1'b1, 1'b0);
    checkValue("misaligned_rdata", rdata, 32'hDEAD_BEEF);
    cycle(R_STAT, 32'h0, 1'b1, 1'b0);
    checkValue("status_3", rdata, 32'h3);
    cycle(R_EADR, 32'h0, 1'b1, 1'b0);
    checkValue("erraddr_kept", rdata, 32'h0000_1000);

    // W1C clear
    cycle(R_STAT, 32'h3, 1'b0, 1'b1);
    cycle(R_STAT, 32'h0, 1'b1, 1'b0);
    checkValue("status_cleared", rdata, 32'h0);
    idle();
    checkValue("err_cleared", err, 1'b0);

    // Read+write conflict: write performed, read data zero
    cycle(32'h0000_0020, 32'hA5A5_A5A5, 1'b1, 1'b1);
    checkValue("conflict_rdata", rdata, 32'h0);
    cycle(R_STAT, 32'h0, 1'b1, 1'b0);
    checkValue("status_conflict", rdata, 32'h4);
    cycle(R_EADR, 32'h0, 1'b1, 1'b0);
    checkValue("erraddr_20", rdata, 32'h0000_0020);
    cycle(32'h0000_0020, 32'h0, 1'b1, 1'b0);
    checkValue("conflict_write_kept", rdata, 32'hA5A5_A5A5);
    cycle(R_STAT, 32'h4, 1'b0, 1'b1);

    // Misaligned conflict: bits 0 and 2, write dropped
    cycle(32'h0000_0022, 32'h1111_1111, 1'b1, 1'b1);
    cycle(R_STAT, 32'h0, 1'b1, 1'b0);
    checkValue("status_mis_conflict", rdata, 32'h5);
    cycle(R_EADR, 32'h0, 1'b1, 1'b0);
    checkValue("erraddr_22", rdata, 32'h0000_0022);
    cycle(32'h0000_0020, 32'h0, 1'b1, 1'b0);
    checkValue("mis_write_dropped", rdata, 32'hA5A5_A5A5);
    cycle(R_STAT, 32'h7, 1'b0, 1'b1);

    // Same-edge clear and set of bit2: set wins, bit1 clears, ERR_ADDR holds
    cycle(32'h0000_2000, 32'h0, 1'b1, 1'b0);
    cycle(R_STAT, 32'h6, 1'b1, 1'b1);
    cycle(R_STAT, 32'h0, 1'b1, 1'b0);
    checkValue("status_set_wins", rdata, 32'h4);
    cycle(R_EADR, 32'h0, 1'b1, 1'b0);
    checkValue("erraddr_2000", rdata, 32'h0000_2000);
    cycle(R_STAT, 32'h4, 1'b0, 1'b1);

    // Scratch, unused window offset, RO write ignored
    cycle(R_SCR, 32'hCAFE_F00D, 1'b0, 1'b1);
    cycle(R_SCR, 32'h0, 1'b1, 1'b0);
    checkValue("scratch_rw", rdata, 32'hCAFE_F00D);
    cycle(32'hFFFF_0020, 32'h0, 1'b1, 1'b0);
    checkValue("window_hole", rdata, 32'h0);
    cycle(R_LO, 32'h0, 1'b0, 1'b1);
    cycle(R_LO, 32'h0, 1'b1, 1'b0);
    checkValue("cycle_lo_ro", rdata, modelCount[31:0]);
    cycle(R_STAT, 32'h0, 1'b1, 1'b0);
    checkValue("no_error_mmio", rdata, 32'h0);

    // Reset mid write while err is high
    cycle(32'h0000_0003, 32'h0, 1'b1, 1'b0);
    idle();
    idle();
    checkValue("err_before_reset", err, 1'b1);
    cycle(R_SCR, 32'h0000_0001, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    checkValue("err_async_clear", err, 1'b0);
    idle();
    @(negedge clock);
    reset = 1'b0; modelCount = 0;
    cycle(R_SCR, 32'h0, 1'b1, 1'b0);
    checkValue("scratch_after_reset", rdata, 32'h0);
    cycle(R_LO, 32'h0, 1'b1, 1'b0);
    checkValue("cycle_lo_after_reset", rdata, modelCount[31:0]);

    // Counter LO rollover carries into the HI snapshot
    @(negedge clock);
    force dut.uMmioRegs.cycleCountReg = 64'h0000_0000_FFFF_FFF8;
    idle();
    release dut.uMmioRegs.cycleCountReg;
    repeat (16) idle();
    cycle(R_LO, 32'h0, 1'b1, 1'b0);
    loSnap = rdata;
    checkValue("lo_wrapped_small", loSnap[31:5], 27'h0);
    cycle(R_HI, 32'h0, 1'b1, 1'b0);
    checkValue("hi_after_rollover", rdata, 32'h1);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
